// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, writeback request type and arbiter states
package wb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS_DEF);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_req_t;
  typedef enum logic {ALU_PRI, LD_PRI} wb_state_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: load result FIFO exposing count and per-entry valid/rd for busy tracking
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic                                pop,
  input  wb_req_t                             din,
  output wb_req_t                             dout,
  output logic [CW-1:0]                       count,
  output logic [DEPTH-1:0]                    ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd
);
  wb_req_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && count < CW'(DEPTH);
  assign do_pop = pop && count != '0;
  assign dout = mem[rp];
  for (genvar i = 0; i < DEPTH; i++) begin : g_rd
    assign ent_rd[i] = mem[i].rd;
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ent_vld <= '0;
    end else begin
      if (do_push) begin
        wp <= wp + 1'b1;
        ent_vld[wp] <= 1'b1;
      end
      if (do_pop) begin
        rp <= rp + 1'b1;
        ent_vld[rp] <= 1'b0;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and buffered load results onto the register-file write port
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int LD_DEPTH = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(LD_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid_i,
  output logic                alu_ready_o,
  input  logic [AW-1:0]       alu_rd_i,
  input  logic [XLEN-1:0]     alu_data_i,
  input  logic                ld_valid_i,
  output logic                ld_ready_o,
  input  logic [AW-1:0]       ld_rd_i,
  input  logic [XLEN-1:0]     ld_data_i,
  output logic                wr_en_o,
  output logic [AW-1:0]       rd_addr_o,
  output logic [XLEN-1:0]     rd_data_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                waw_err_o
);
  wb_state_e state, state_nx;
  wb_req_t head, sel;
  logic sel_vld, pop, alu_hs;
  logic [CW-1:0] count;
  logic [LD_DEPTH-1:0] ent_vld;
  logic [LD_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  assign ld_ready_o = count < CW'(LD_DEPTH);
  assign alu_ready_o = state == ALU_PRI;
  assign alu_hs = alu_valid_i && alu_ready_o;
  wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(ld_valid_i && ld_ready_o && ld_rd_i != '0),
    .pop(pop),
    .din(wb_req_t'{rd: ld_rd_i, data: ld_data_i}),
    .dout(head),
    .count(count),
    .ent_vld(ent_vld),
    .ent_rd(ent_rd)
  );
  always_comb begin
    pop = count != '0 && !alu_hs;
    sel_vld = alu_hs || pop;
    sel = alu_hs ? wb_req_t'{rd: alu_rd_i, data: alu_data_i} : head;
    state_nx = state == ALU_PRI ? (alu_valid_i && count == CW'(LD_DEPTH) ? LD_PRI : ALU_PRI)
                                : (count - CW'(pop) < CW'(LD_DEPTH - 1) ? ALU_PRI : LD_PRI);
  end
  always_comb begin
    busy_o = '0;
    for (int i = 0; i < LD_DEPTH; i++) if (ent_vld[i]) busy_o[ent_rd[i]] = 1'b1;
    busy_o[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ALU_PRI;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_o <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
      waw_err_o <= 1'b0;
    end else begin
      wr_en_o <= sel_vld && sel.rd != '0;
      if (sel_vld && sel.rd != '0) begin
        rd_addr_o <= sel.rd;
        rd_data_o <= sel.data;
      end
      if (alu_hs && alu_rd_i != '0 && busy_o[alu_rd_i]) waw_err_o <= 1'b1;
    end
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback unit that drives the single write port of the register file.
- Merges two result sources:
  - the ALU/execute pipeline, which expects to be accepted every cycle;
  - the load unit, whose results arrive at arbitrary times.
- Load results are buffered in a small FIFO; writes to x0 are discarded.
- Exports a per-register pending-write mask so the hazard logic can stall readers and WAW writers.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, architectural register count (address width = $clog2(NUM_REGS)).
- LD_DEPTH, 4, load FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid_i  in  1  ALU result present.
- alu_ready_o  out  1  ALU result accepted this cycle.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- ld_valid_i  in  1  load result present.
- ld_ready_o  out  1  load FIFO can accept.
- ld_rd_i  in  5  load destination register.
- ld_data_i  in  XLEN  load result.
- wr_en_o  out  1  register-file write enable (registered).
- rd_addr_o  out  5  register-file write address (registered).
- rd_data_o  out  XLEN  register-file write data (registered).
- busy_o  out  NUM_REGS  bit r = 1 when a buffered load targets xr; bit 0 is always 0.
- waw_err_o  out  1  sticky: ALU write accepted to a register with busy_o set.

Behaviour:
- Reset (async assert, sync deassert by design):
  - wr_en_o=0, rd_addr_o=0, rd_data_o=0, waw_err_o=0.
  - FIFO emptied: ptrs=0, count=0, busy_o=0.
- Handshake: a transfer occurs when valid & ready are both high on a clock edge. Payload is held stable by the source while valid & !ready.
- ld_ready_o = (count < LD_DEPTH). It is combinational from state only, with no dependency on ld_valid_i.
- Load accept with ld_rd_i==0: the handshake completes, nothing is enqueued, and no write is ever issued.
- Arbitration FSM, two states:
  - ALU_PRI (reset state):
    - alu_ready_o=1.
    - If alu_valid_i, the ALU result is selected. Otherwise the FIFO head is selected if count>0.
    - Go to LD_PRI when count==LD_DEPTH and alu_valid_i (starvation guard).
  - LD_PRI:
    - alu_ready_o=0; the FIFO head is selected and popped.
    - Return to ALU_PRI when count after the pop is < LD_DEPTH-1, or when count reaches 0.
- Output stage: the selected entry is registered at the edge.
  - wr_en_o=1 the following cycle, with rd_addr_o/rd_data_o holding it.
  - If nothing is selected, or the selected rd==0, then wr_en_o=0. Address/data hold their previous values.
- Latency:
  - ALU result valid in cycle N gives wr_en_o in cycle N+1.
  - Load accepted in cycle N enters the FIFO at end of N, is earliest selectable in N+1, and gives wr_en_o in N+2.
- Simultaneous push and pop in the same cycle: allowed. Count is unchanged and a full FIFO still accepts nothing that cycle (ld_ready_o was 0).
- Pointers wrap modulo LD_DEPTH.
- busy_o[r] = OR over valid FIFO entries of (entry.rd==r). It updates the cycle after push/pop. Loads are returned in order, so a later load to the same rd is written after an earlier one.
- waw_err_o: set at the edge where an ALU handshake occurs with alu_rd_i!=0 and busy_o[alu_rd_i]==1. It is cleared only by rst.
- Reset mid-operation: all buffered loads are discarded immediately. No write is issued after reset asserts.

Decomposition:
- Package wb_pkg:
  - XLEN_DEF, REG_ADDR_W;
  - typedef wb_req_t {rd, data};
  - enum wb_state_e {ALU_PRI, LD_PRI}.
- One sub-module, wb_fifo: a synchronous FIFO of wb_req_t, depth LD_DEPTH, with count and per-entry valid/rd exposed for busy_o generation.
- The arbiter, output register and error flag stay in wb_arbiter.

Test Plan:
1. ALU only:
   - Stimulus: alu x1=0x12345678 in cycle N, then x0=0xDEADBEEF in N+1.
   - Required: wr_en_o=1 with rd_addr_o=1, rd_data_o=0x12345678 in N+1; wr_en_o=0 in N+2; busy_o=0 throughout.
2. Load only:
   - Stimulus: load x5=0xAAAAAAAA accepted in N.
   - Required: busy_o[5]=1 in N+1; write x5=0xAAAAAAAA in N+2; busy_o[5]=0 in N+2.
3. Contention:
   - Stimulus: ALU valid every cycle to x2..x9 while 4 loads to x10..x13 arrive.
   - Required: ld_ready_o=0 once count=4, and the FSM enters LD_PRI with alu_ready_o=0. All 12 writes appear exactly once, with loads in order x10..x13.
4. Same-rd loads:
   - Stimulus: loads x7=0x1 then x7=0x2.
   - Required: writes appear in the order 0x1 then 0x2; busy_o[7] stays 1 until the second write is issued.
5. WAW error:
   - Stimulus: load to x3 buffered; ALU write to x3 accepted while busy_o[3]=1.
   - Required: waw_err_o=1 next cycle and it stays 1 until rst.
6. Reset mid-operation:
   - Stimulus: 3 loads buffered; assert rst asynchronously between edges.
   - Required: wr_en_o, busy_o and waw_err_o drop to 0 immediately; no writes occur after rst deasserts.
